// File: rtl/rab_lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rab_lookup_arbiter
//  Purpose  : Round-robin arbiter sharing the single RAB lookup/translation
//             path between two slave-port address channels. One requester is
//             granted per lookup. Further grants are held until the granted
//             port reports done. A watchdog frees the path if done never comes.
//  Ports    : Clk_CI / Rst_RBI        clock, asynchronous active-low reset
//             portN_addr_valid_i/_i   requester valid and address (N = 1, 2)
//             portN_done_i            granted transaction sent / dropped
//             lookup_valid_o          one-cycle strobe, lookup_addr_o/select_o valid
//             lookup_addr_o, select_o address and owner (1 = port1) for lookup
//             portN_grant_o           one-cycle grant pulse
//             busy_o                  lookup path owned (state != IDLE)
//             timeout_o               one-cycle watchdog-expiry pulse
//  Options  : RAB_ARB_PERF_CNT_EN adds perf_clr_i and saturating 32-bit
//             per-port grant counters port1_grant_cnt_o / port2_grant_cnt_o.
//  Revision : 1.0 - initial release
// ============================================================================
module rab_lookup_arbiter #(
   parameter int unsigned AXI_ADDR_WIDTH = 40,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned TO_CNT_WIDTH   = 9
) (
   input  logic                      Clk_CI,
   input  logic                      Rst_RBI,
   input  logic                      port1_addr_valid_i,
   input  logic [AXI_ADDR_WIDTH-1:0] port1_addr_i,
   input  logic                      port2_addr_valid_i,
   input  logic [AXI_ADDR_WIDTH-1:0] port2_addr_i,
   input  logic                      port1_done_i,
   input  logic                      port2_done_i,
`ifdef RAB_ARB_PERF_CNT_EN
   input  logic                      perf_clr_i,
   output logic [31:0]               port1_grant_cnt_o,
   output logic [31:0]               port2_grant_cnt_o,
`endif
   output logic                      lookup_valid_o,
   output logic [AXI_ADDR_WIDTH-1:0] lookup_addr_o,
   output logic                      select_o,
   output logic                      port1_grant_o,
   output logic                      port2_grant_o,
   output logic                      busy_o,
   output logic                      timeout_o
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LOOKUP    = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_t;

   // Last watchdog count before expiry; unused when the watchdog is disabled.
   localparam logic [TO_CNT_WIDTH-1:0] TO_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

   state_t                    state_q;
   logic                      prio_p1_q;    // 1 = port1 wins a tie
   logic [TO_CNT_WIDTH-1:0]   to_cnt_q;
   logic                      lookup_valid_q;
   logic [AXI_ADDR_WIDTH-1:0] lookup_addr_q;
   logic                      select_q;
   logic                      port1_grant_q;
   logic                      port2_grant_q;
   logic                      busy_q;
   logic                      timeout_q;

   logic                      req_any_d;
   logic                      win_p1_d;
   logic                      granted_done_d;
   logic                      to_hit_d;

   always_comb begin
      req_any_d      = port1_addr_valid_i | port2_addr_valid_i;
      // port1 wins when it is the only requester or holds priority in a tie
      win_p1_d       = port1_addr_valid_i & (~port2_addr_valid_i | prio_p1_q);
      // only the owner's done matters; the other port's done is ignored
      granted_done_d = select_q ? port1_done_i : port2_done_i;
      to_hit_d       = WDOG_EN && (to_cnt_q == TO_LAST);
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_q        <= S_IDLE;
         prio_p1_q      <= 1'b1;
         to_cnt_q       <= '0;
         lookup_valid_q <= 1'b0;
         lookup_addr_q  <= '0;
         select_q       <= 1'b0;
         port1_grant_q  <= 1'b0;
         port2_grant_q  <= 1'b0;
         busy_q         <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         // pulse outputs default low every cycle
         lookup_valid_q <= 1'b0;
         port1_grant_q  <= 1'b0;
         port2_grant_q  <= 1'b0;
         timeout_q      <= 1'b0;

         case (state_q)
            S_IDLE: begin
               // select/address hold their last values while idle
               if (req_any_d) begin
                  select_q       <= win_p1_d;
                  lookup_addr_q  <= win_p1_d ? port1_addr_i : port2_addr_i;
                  lookup_valid_q <= 1'b1;
                  port1_grant_q  <= win_p1_d;
                  port2_grant_q  <= ~win_p1_d;
                  busy_q         <= 1'b1;
                  state_q        <= S_LOOKUP;
               end
            end

            S_LOOKUP: begin
               prio_p1_q <= ~select_q;   // loser gets next tie
               to_cnt_q  <= '0;
               if (granted_done_d) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  state_q <= S_WAIT_DONE;
               end
            end

            S_WAIT_DONE: begin
               if (granted_done_d) begin
                  // done wins over a same-cycle watchdog expiry
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (to_hit_d) begin
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else if (WDOG_EN) begin
                  to_cnt_q <= to_cnt_q + TO_CNT_WIDTH'(1);
               end
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign lookup_valid_o = lookup_valid_q;
   assign lookup_addr_o  = lookup_addr_q;
   assign select_o       = select_q;
   assign port1_grant_o  = port1_grant_q;
   assign port2_grant_o  = port2_grant_q;
   assign busy_o         = busy_q;
   assign timeout_o      = timeout_q;

`ifdef RAB_ARB_PERF_CNT_EN
   logic [31:0] p1_cnt_q;
   logic [31:0] p2_cnt_q;

   // Count grant pulses; clear wins over increment; saturate at all-ones.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         p1_cnt_q <= '0;
         p2_cnt_q <= '0;
      end else if (perf_clr_i) begin
         p1_cnt_q <= '0;
         p2_cnt_q <= '0;
      end else begin
         if (port1_grant_q && (p1_cnt_q != 32'hFFFF_FFFF))
            p1_cnt_q <= p1_cnt_q + 32'd1;
         if (port2_grant_q && (p2_cnt_q != 32'hFFFF_FFFF))
            p2_cnt_q <= p2_cnt_q + 32'd1;
      end
   end

   assign port1_grant_cnt_o = p1_cnt_q;
   assign port2_grant_cnt_o = p2_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rab_lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rab_lookup_arbiter
//  Purpose  : Self-checking bench for rab_lookup_arbiter. Stimulus pushes the
//             expected lookup (owner + address) into a queue; a monitor pops
//             and compares whenever lookup_valid_o is seen. Directed checks
//             cover busy/timeout timing, reset and optional grant counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rab_lookup_arbiter;

   localparam int unsigned AW = 40;

   typedef struct packed {
      logic          sel;
      logic [AW-1:0] addr;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          v1, v2, d1, d2;
   logic [AW-1:0] a1, a2;
   logic          lookup_valid, select, g1, g2, busy, tmo;
   logic [AW-1:0] lookup_addr;
`ifdef RAB_ARB_PERF_CNT_EN
   logic          perf_clr;
   logic [31:0]   cnt1, cnt2;
`endif

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   rab_lookup_arbiter #(
      .AXI_ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(8),
      .TO_CNT_WIDTH  (4)
   ) dut (
      .Clk_CI            (clk),
      .Rst_RBI           (rst_n),
      .port1_addr_valid_i(v1),
      .port1_addr_i      (a1),
      .port2_addr_valid_i(v2),
      .port2_addr_i      (a2),
      .port1_done_i      (d1),
      .port2_done_i      (d2),
`ifdef RAB_ARB_PERF_CNT_EN
      .perf_clr_i        (perf_clr),
      .port1_grant_cnt_o (cnt1),
      .port2_grant_cnt_o (cnt2),
`endif
      .lookup_valid_o    (lookup_valid),
      .lookup_addr_o     (lookup_addr),
      .select_o          (select),
      .port1_grant_o     (g1),
      .port2_grant_o     (g2),
      .busy_o            (busy),
      .timeout_o         (tmo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_lookup_valid"}, 64'(lookup_valid), 64'd0);
      chk({tag, "_lookup_addr"},  64'(lookup_addr),  64'd0);
      chk({tag, "_select"},       64'(select),       64'd0);
      chk({tag, "_grant1"},       64'(g1),           64'd0);
      chk({tag, "_grant2"},       64'(g2),           64'd0);
      chk({tag, "_busy"},         64'(busy),         64'd0);
      chk({tag, "_timeout"},      64'(tmo),          64'd0);
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0;
      v1 = 0; v2 = 0; d1 = 0; d2 = 0;
      tick();
      rst_n = 1'b1;
   endtask

   // single port1 lookup that completes in its own LOOKUP cycle
   task automatic grant_p1_early(input logic [AW-1:0] addr);
      v1 = 1'b1; a1 = addr;
      exp_q.push_back('{sel: 1'b1, addr: addr});
      tick();          // LOOKUP
      d1 = 1'b1;
      tick();          // IDLE
      v1 = 1'b0; d1 = 1'b0;
      tick();
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (lookup_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_lookup", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sb_select", 64'(select),      64'(e.sel));
               chk("sb_addr",   64'(lookup_addr), 64'(e.addr));
               chk("sb_grant1", 64'(g1),          64'(e.sel));
               chk("sb_grant2", 64'(g2),          64'(!e.sel));
            end
         end else if (g1 || g2) begin
            chk("grant_without_lookup", {62'd0, g1, g2}, 64'd0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] c1 [0:1];
      logic [AW-1:0] c2 [0:1];
      c1[0] = 40'h11_0000_1000; c1[1] = 40'h11_0000_2000;
      c2[0] = 40'h22_0000_1000; c2[1] = 40'h22_0000_2000;

      rst_n = 1'b0;
      v1 = 0; v2 = 0; d1 = 0; d2 = 0;
      a1 = '0; a2 = '0;
`ifdef RAB_ARB_PERF_CNT_EN
      perf_clr = 1'b0;
`endif

      // ---- reset state ----
      tick();
      chk_all_zero("reset");
      rst_n = 1'b1;

      // ---- single requester ----
      tick();                                  // cycle 0
      v1 = 1'b1; a1 = 40'h12_3456_7000;
      exp_q.push_back('{sel: 1'b1, addr: 40'h12_3456_7000});
      tick();                                  // cycle 1: LOOKUP
      chk("single_lookup_valid_c1", 64'(lookup_valid), 64'd1);
      chk("single_busy_c1", 64'(busy), 64'd1);
      tick(); chk("single_busy_c2", 64'(busy), 64'd1);
      tick(); chk("single_busy_c3", 64'(busy), 64'd1);
      tick(); chk("single_busy_c4", 64'(busy), 64'd1);
      d1 = 1'b1;                               // done at cycle 4
      tick();                                  // cycle 5
      chk("single_busy_c5", 64'(busy), 64'd0);
      chk("single_addr_hold", 64'(lookup_addr), 64'h12_3456_7000);
      chk("single_select_hold", 64'(select), 64'd1);
      v1 = 1'b0; d1 = 1'b0;

      // ---- contention: p1, p2, p1, p2 after reset ----
      do_reset();
      v1 = 1'b1; v2 = 1'b1; a1 = c1[0]; a2 = c2[0];
      for (int i = 0; i < 4; i++) begin
         logic win1;
         win1 = (i % 2 == 0);
         exp_q.push_back('{sel: win1, addr: win1 ? a1 : a2});
         tick();                               // G: LOOKUP
         chk("cont_select", 64'(select), 64'(win1));
         tick(); tick(); tick();               // G+3
         if (win1) d1 = 1'b1; else d2 = 1'b1;
         tick();                               // G+4: IDLE
         chk("cont_idle_busy", 64'(busy), 64'd0);
         d1 = 1'b0; d2 = 1'b0;
         if (win1) a1 = c1[1]; else a2 = c2[1];
         if (i == 3) begin v1 = 1'b0; v2 = 1'b0; end
      end

      // ---- early done skips WAIT_DONE ----
      tick();
      v2 = 1'b1; a2 = 40'h33_AAAA_0000;
      exp_q.push_back('{sel: 1'b0, addr: 40'h33_AAAA_0000});
      tick();                                  // L: LOOKUP
      d2 = 1'b1;
      tick();                                  // L+1: IDLE
      chk("early_busy", 64'(busy), 64'd0);
      d2 = 1'b0; a2 = 40'h33_BBBB_0000;
      exp_q.push_back('{sel: 1'b0, addr: 40'h33_BBBB_0000});
      tick();                                  // L+2: LOOKUP again
      chk("early_regrant", 64'(lookup_valid), 64'd1);
      d2 = 1'b1;
      tick();
      v2 = 1'b0; d2 = 1'b0;

      // ---- watchdog expiry (TIMEOUT_CYCLES = 8) ----
      tick();
      v1 = 1'b1; a1 = 40'h44_0000_0040;
      exp_q.push_back('{sel: 1'b1, addr: 40'h44_0000_0040});
      tick();                                  // LOOKUP
      for (int k = 0; k < 8; k++) begin        // E .. E+7
         tick();
         chk("wdog_no_early_timeout", 64'(tmo), 64'd0);
         chk("wdog_busy_wait", 64'(busy), 64'd1);
      end
      tick();                                  // E+8
      chk("wdog_timeout_pulse", 64'(tmo), 64'd1);
      chk("wdog_idle_after", 64'(busy), 64'd0);
      v1 = 1'b0;
      tick();
      chk("wdog_single_pulse", 64'(tmo), 64'd0);

      // ---- watchdog with done in the expiry cycle ----
      v1 = 1'b1; a1 = 40'h44_0000_0080;
      exp_q.push_back('{sel: 1'b1, addr: 40'h44_0000_0080});
      tick();                                  // LOOKUP
      for (int k = 0; k < 8; k++) tick();      // ends at E+7
      d1 = 1'b1;
      tick();                                  // E+8
      chk("wdog_done_wins_tmo", 64'(tmo), 64'd0);
      chk("wdog_done_wins_busy", 64'(busy), 64'd0);
      v1 = 1'b0; d1 = 1'b0;
      tick();
      chk("wdog_done_wins_tmo2", 64'(tmo), 64'd0);

      // ---- wrong-port done ignored ----
      v1 = 1'b1; a1 = 40'h55_0000_0100;
      exp_q.push_back('{sel: 1'b1, addr: 40'h55_0000_0100});
      tick();                                  // G: LOOKUP
      tick();                                  // G+1: WAIT_DONE
      d2 = 1'b1; v2 = 1'b1; a2 = 40'h66_0000_0200;
      tick();
      d2 = 1'b0;
      chk("wrong_done_busy", 64'(busy), 64'd1);
      tick();
      chk("wrong_done_busy2", 64'(busy), 64'd1);
      chk("wrong_done_no_lookup", 64'(lookup_valid), 64'd0);
      chk("wrong_done_select_stable", 64'(select), 64'd1);
      chk("wrong_done_addr_stable", 64'(lookup_addr), 64'h55_0000_0100);
      d1 = 1'b1;
      tick();                                  // IDLE
      chk("wrong_done_release", 64'(busy), 64'd0);
      d1 = 1'b0; v1 = 1'b0;
      exp_q.push_back('{sel: 1'b0, addr: 40'h66_0000_0200});
      tick();                                  // port2 LOOKUP
      d2 = 1'b1;
      tick();
      v2 = 1'b0; d2 = 1'b0;

      // ---- asynchronous reset mid-WAIT_DONE ----
      tick();
      v1 = 1'b1; a1 = 40'h77_0000_0300;
      exp_q.push_back('{sel: 1'b1, addr: 40'h77_0000_0300});
      tick();                                  // LOOKUP
      tick();                                  // WAIT_DONE
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      v1 = 1'b0;
      tick();
      rst_n = 1'b1;
      v1 = 1'b1; v2 = 1'b1; a1 = 40'h77_0000_0400; a2 = 40'h88_0000_0500;
      exp_q.push_back('{sel: 1'b1, addr: 40'h77_0000_0400});
      tick();                                  // port1 LOOKUP first
      chk("post_rst_p1_first", 64'(g1), 64'd1);
      d1 = 1'b1;
      tick();                                  // IDLE
      v1 = 1'b0; d1 = 1'b0;
      exp_q.push_back('{sel: 1'b0, addr: 40'h88_0000_0500});
      tick();                                  // port2 LOOKUP
      d2 = 1'b1;
      tick();
      v2 = 1'b0; d2 = 1'b0;

`ifdef RAB_ARB_PERF_CNT_EN
      // ---- grant counters ----
      do_reset();
      grant_p1_early(40'h99_0000_0001);
      grant_p1_early(40'h99_0000_0002);
      grant_p1_early(40'h99_0000_0003);
      tick();
      chk("perf_cnt1_3", 64'(cnt1), 64'd3);
      chk("perf_cnt2_0", 64'(cnt2), 64'd0);
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      chk("perf_cnt1_clr", 64'(cnt1), 64'd0);
`endif

      tick(); tick();
      chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rab_lookup_arbiter.md
Name: rab_lookup_arbiter

Overview:
- Shares the single RAB lookup/translation path between the two slave-port address channels (port1, port2).
- Picks one requester per lookup using round-robin and drives the select and address into the lookup path.
- Holds further grants until the granted port reports its transaction sent or dropped.
- A watchdog releases the lookup path if the granted port never completes.

Parameters:
AXI_ADDR_WIDTH, 40, width of the requester and lookup addresses
TIMEOUT_CYCLES, 256, watchdog limit in WAIT_DONE cycles; 0 disables the watchdog
TO_CNT_WIDTH, 9, watchdog counter width; must satisfy 2^TO_CNT_WIDTH > TIMEOUT_CYCLES

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  asynchronous active-low reset
port1_addr_valid_i  in  1  port1 address request pending
port1_addr_i  in  AXI_ADDR_WIDTH  port1 request address
port2_addr_valid_i  in  1  port2 address request pending
port2_addr_i  in  AXI_ADDR_WIDTH  port2 request address
port1_done_i  in  1  port1 transaction sent or drop-response complete
port2_done_i  in  1  port2 transaction sent or drop-response complete
lookup_valid_o  out  1  one-cycle strobe: lookup_addr_o/select_o valid for lookup
lookup_addr_o  out  AXI_ADDR_WIDTH  address presented to the lookup path
select_o  out  1  1 = port1 owns the lookup, 0 = port2
port1_grant_o  out  1  one-cycle pulse, port1 granted
port2_grant_o  out  1  one-cycle pulse, port2 granted
busy_o  out  1  lookup path owned (state != IDLE)
timeout_o  out  1  one-cycle pulse, watchdog expired

Behaviour:
- Reset: Clk_CI is the single clock. Rst_RBI is asynchronous and active-low.
  - All outputs reset to 0; lookup_addr_o resets to '0.
  - State resets to IDLE, round-robin priority to port1, watchdog counter to 0.
  - Reset asserted mid-operation aborts the transaction immediately; no pulse is emitted.
- States: IDLE, LOOKUP, WAIT_DONE. All outputs are registered.
- IDLE:
  - Only port1 valid: grant port1. Only port2 valid: grant port2.
  - Both valid: grant the port holding round-robin priority.
  - On a grant: register select_o and lookup_addr_o from the winner's address, then go to LOOKUP.
  - No valid: stay in IDLE; lookup_addr_o and select_o hold their previous values.
- LOOKUP (exactly 1 cycle):
  - lookup_valid_o = 1 and the winner's grant pulse = 1.
  - Priority moves to the loser.
  - Next state is WAIT_DONE, or IDLE if the granted port's done is already high in this cycle.
- Latency: valid sampled in IDLE at cycle N gives lookup_valid_o at cycle N+1.
- WAIT_DONE:
  - Granted port's done = 1: go to IDLE.
  - Non-granted port's done: ignored entirely.
  - Earliest next grant: the cycle after done is sampled in IDLE, so 2 cycles from done to the next lookup_valid_o.
- Watchdog (WAIT_DONE only):
  - The counter clears on entry to WAIT_DONE and increments each cycle in it.
  - If the counter reaches TIMEOUT_CYCLES-1 with no done: timeout_o pulses for 1 cycle and the state goes to IDLE.
  - Done in that same cycle wins: no timeout, normal return to IDLE.
  - TIMEOUT_CYCLES=0: the counter never increments and timeout_o stays 0.
- Requester rules:
  - A requester holds valid and address stable until its done.
  - A valid that drops before grant is not latched.
  - Address changes after LOOKUP are ignored because lookup_addr_o is registered.
- select_o and lookup_addr_o are stable from LOOKUP through WAIT_DONE.

Optional Feature:
RAB_ARB_PERF_CNT_EN
- Defined:
  - Adds inputs perf_clr_i (1) and outputs port1_grant_cnt_o and port2_grant_cnt_o (32 each).
  - Each counter increments on its grant pulse and saturates at 32'hFFFF_FFFF.
  - perf_clr_i clears both counters synchronously and wins over a same-cycle increment.
  - Both counters reset to 0.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single requester: port1 valid at cycle 0, addr 40'h12_3456_7000, done at cycle 4.
  - Expected: lookup_valid_o=1, select_o=1, lookup_addr_o=40'h12_3456_7000 and port1_grant_o at cycle 1.
  - busy_o is 1 for cycles 1..4 and 0 at cycle 5.
- Contention: both valid continuously, each done 3 cycles after its grant.
  - Expected: grants alternate port1, port2, port1, port2, starting with port1 after reset; select_o toggles accordingly.
- Early done: port2 valid with port2_done_i high in the LOOKUP cycle.
  - Expected: WAIT_DONE is skipped; a new grant is possible 2 cycles after lookup_valid_o.
- Watchdog: TIMEOUT_CYCLES=8, port1 granted, no done.
  - Expected: timeout_o pulses exactly once, 8 cycles after entering WAIT_DONE, then IDLE.
  - Repeat with done in the expiry cycle: expect no timeout_o.
- Wrong-port done: port1 granted, port2_done_i pulses.
  - Expected: state is unchanged and no grant is issued until port1_done_i.
- Reset mid-WAIT_DONE: assert Rst_RBI low asynchronously.
  - Expected: all outputs 0 at once; after release, both ports valid gives port1 granted first.
  - With RAB_ARB_PERF_CNT_EN defined: 3 port1 grants give port1_grant_cnt_o=3; perf_clr_i returns it to 0.
